fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset (reset==0 resets immediately, regardless of clk).
REQ-003 SHALL have port lock  in  1  stall from hazard unit; 1 = hold the current PC and the delivered instruction.
REQ-004 SHALL have ports I_br_taken  in  1 and I_br_target  in  32  redirect resolved in the decode stage.
REQ-005 SHALL have port I_jump  in  1  decode stage holds a branch or jump, so the current fetch is a delay slot.
REQ-006 SHALL have ports I_exc_req  in  1 and I_eret  in  1 and I_epc  in  32  exception entry / return request.
REQ-007 SHALL have ports im_req  out  1, im_addr  out  32, im_ack  in  1 and im_rdata  in  32  instruction-memory handshake.
REQ-008 SHALL have ports O_pc  out  32, O_ins  out  32, O_ex  out  5 and O_bd  out  1  fetched bundle feeding the decode pipeline register.
REQ-009 SHALL have port O_fstall  out  1  fetch not ready; OR-ed into lock by the hazard unit.

Function
REQ-010 SHALL hold PC register pc; next-PC priority: I_exc_req -> 0x0000_4180, else I_eret -> I_epc, else I_br_taken -> I_br_target, else pc+4 (modulo 2^32).
REQ-011 SHALL implement FSM states IDLE, REQ, DROP and HOLD.
REQ-012 IDLE: first cycle after reset release; next state is REQ; im_req=0.
REQ-013 REQ: im_req=1, im_addr=pc; on im_ack the FSM SHALL latch O_ins<=im_rdata, O_pc<=pc and O_bd<=I_jump, advance pc, and go to HOLD if lock, else stay in REQ.
REQ-014 In REQ without im_ack, O_fstall SHALL be 1 and pc/O_* SHALL be held.
REQ-015 HOLD: im_req=0; outputs held while lock; when lock falls, return to REQ.
REQ-016 A redirect (exc/eret/branch) in REQ before im_ack SHALL load pc with the target and enter DROP.
REQ-017 In DROP, the next im_ack SHALL be discarded and the FSM SHALL return to REQ without updating outputs; O_fstall=1 throughout DROP.
REQ-018 I_exc_req SHALL override lock, set O_ins=0 and O_ex=0, and set O_bd=0 in the same edge (flush).
REQ-019 When I_exc_req and I_br_taken are both asserted, the exception target SHALL win; I_br_taken SHALL be ignored.
REQ-020 O_bd SHALL equal the I_jump value sampled at the accepting edge.
REQ-021 Fetch latency SHALL be 1 cycle minimum (im_ack in the same cycle as im_req).

Reset
REQ-022 While reset==0: pc=0x0000_3000, O_pc=0x0000_3000, O_ins=0, O_ex=0, O_bd=0, im_req=0, O_fstall=1, FSM=IDLE.
REQ-023 Reset asserted mid-request SHALL drop the outstanding request; any later im_ack SHALL be ignored until REQ is re-entered.

Configuration
REQ-024 With FETCH_ADEL_CHECK_EN defined: if pc[1:0]!=0 or pc is outside [0x3000,0x6FFC], the unit SHALL issue no im_req, SHALL produce O_ex=4 (AdEL) and O_ins=0 for that slot, and SHALL accept the slot in one cycle.
REQ-025 Without FETCH_ADEL_CHECK_EN: O_ex SHALL be constant 0 and every PC SHALL be fetched.

Structure
REQ-026 Shared package cpu_pkg SHALL hold: RESET_PC=0x3000, EXC_VECTOR=0x4180, IM_LO=0x3000, IM_HI=0x6FFC, EXC_ADEL=5'd4, and the FSM state enum.
REQ-027 A sub-module npc_sel SHALL be used (combinational next-PC priority mux); the FSM and registers SHALL stay in fetch_unit.

Verification
REQ-028 Release reset, im_ack always 1, lock 0 -> im_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; O_pc trails by one cycle.
REQ-029 Hold im_ack 0 for 3 cycles at pc 0x3004 -> O_fstall=1 for 3 cycles, then O_ins=im_rdata and O_pc=0x3004.
REQ-030 Redirect I_br_taken=1, target 0x3400, during a pending request -> DROP; stale ack discarded; next im_addr=0x3400.
REQ-031 I_exc_req and I_br_taken together with lock=1 -> pc=0x4180, O_ins=0, O_bd=0 next edge.
REQ-032 FETCH_ADEL_CHECK_EN with I_eret, I_epc=0x3002 -> no im_req; O_ex=4, O_ins=0, O_pc=0x3002.
REQ-033 Assert reset during a pending request with im_ack pulsed after release -> outputs at reset values; first im_addr after release = 0x3000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch stage.
// Address map: reset PC, exception vector and the legal instruction window.
package cpu_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IM_LO      = 32'h0000_3000;
    localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;

    // Fetch controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch and the I-memory.
interface fetch_unit_if;

    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;

    modport master (output im_req, im_addr, input  im_ack, im_rdata);
    modport slave  (input  im_req, im_addr, output im_ack, im_rdata);

endinterface

// File: rtl/npc_sel.sv
// Next-PC priority mux: exception vector, then ERET, then branch, then pc+4.
module npc_sel
    import cpu_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        exc_req_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic [31:0] npc_o,
    output logic        redirect_o
);

    // Priority select of the next fetch address.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        npc_o      = pc_i + 32'd4;
        redirect_o = 1'b1;
        if (exc_req_i) begin
            npc_o = EXC_VECTOR;
        end else if (eret_i) begin
            npc_o = epc_i;
        end else if (br_taken_i) begin
            npc_o = br_target_i;
        end else begin
            redirect_o = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, I-memory handshake FSM and the
// fetched bundle (pc, instruction, exception code, delay-slot flag).
// Build option FETCH_ADEL_CHECK_EN: misaligned or out-of-window PCs are not
// fetched; the slot is completed at once with an AdEL exception code.
module fetch_unit
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                lock,
    input  logic                I_br_taken,
    input  logic [31:0]         I_br_target,
    input  logic                I_jump,
    input  logic                I_exc_req,
    input  logic                I_eret,
    input  logic [31:0]         I_epc,
    fetch_unit_if.master        im,
    output logic [31:0]         O_pc,
    output logic [31:0]         O_ins,
    output logic [4:0]          O_ex,
    output logic                O_bd,
    output logic                O_fstall
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  opc_q;
    logic [31:0]  ins_q;
    logic [4:0]   ex_q;
    logic         bd_q;
    logic         redirect;
    logic         adel;
    logic         slot_done;

    npc_sel u_npc_sel (
        .pc_i        (pc_q),
        .exc_req_i   (I_exc_req),
        .eret_i      (I_eret),
        .epc_i       (I_epc),
        .br_taken_i  (I_br_taken),
        .br_target_i (I_br_target),
        .npc_o       (pc_d),
        .redirect_o  (redirect)
    );

`ifdef FETCH_ADEL_CHECK_EN
    assign adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
`else
    assign adel = 1'b0;
`endif

    // A slot completes in REQ either on a memory ack or on an address error.
    assign slot_done   = (state_q == REQ) && (im.im_ack || adel);

    assign im.im_req   = (state_q == REQ) && !adel;
    assign im.im_addr  = pc_q;
    assign O_pc        = opc_q;
    assign O_ins       = ins_q;
    assign O_ex        = ex_q;
    assign O_bd        = bd_q;
    assign O_fstall    = (state_q == IDLE) || (state_q == DROP) ||
                         ((state_q == REQ) && !slot_done);

    // Fetch FSM together with the PC and fetched-bundle registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            opc_q   <= RESET_PC;
            ins_q   <= '0;
            ex_q    <= EXC_NONE;
            bd_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            unique case (state_q)
                IDLE: state_q <= REQ;

                REQ: begin
                    if (I_exc_req) begin
                        // Flush: anything fetched this edge is discarded; an
                        // unanswered request leaves a stale ack to drop.
                        pc_q    <= pc_d;
                        ins_q   <= '0;
                        ex_q    <= EXC_NONE;
                        bd_q    <= 1'b0;
                        state_q <= slot_done ? REQ : DROP;
                    end else if (slot_done) begin
                        pc_q    <= pc_d;
                        opc_q   <= pc_q;
                        ins_q   <= adel ? 32'd0 : im.im_rdata;
                        ex_q    <= adel ? EXC_ADEL : EXC_NONE;
                        bd_q    <= I_jump;
                        state_q <= lock ? HOLD : REQ;
                    end else if (redirect) begin
                        pc_q    <= pc_d;
                        state_q <= DROP;
                    end
                end

                DROP: begin
                    if (I_exc_req) begin
                        pc_q  <= pc_d;
                        ins_q <= '0;
                        ex_q  <= EXC_NONE;
                        bd_q  <= 1'b0;
                    end
                    if (im.im_ack) begin
                        state_q <= REQ;
                    end
                end

                HOLD: begin
                    if (I_exc_req) begin
                        pc_q    <= pc_d;
                        ins_q   <= '0;
                        ex_q    <= EXC_NONE;
                        bd_q    <= 1'b0;
                        state_q <= REQ;
                    end else if (!lock) begin
                        state_q <= REQ;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        lock;
    logic        I_br_taken;
    logic [31:0] I_br_target;
    logic        I_jump;
    logic        I_exc_req;
    logic        I_eret;
    logic [31:0] I_epc;
    logic [31:0] O_pc;
    logic [31:0] O_ins;
    logic [4:0]  O_ex;
    logic        O_bd;
    logic        O_fstall;

    fetch_unit_if im ();

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .lock        (lock),
        .I_br_taken  (I_br_taken),
        .I_br_target (I_br_target),
        .I_jump      (I_jump),
        .I_exc_req   (I_exc_req),
        .I_eret      (I_eret),
        .I_epc       (I_epc),
        .im          (im),
        .O_pc        (O_pc),
        .O_ins       (O_ins),
        .O_ex        (O_ex),
        .O_bd        (O_bd),
        .O_fstall    (O_fstall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        lock;
        logic        jump;
        logic        br;
        logic [31:0] target;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_fstall;
        logic [31:0] exp_pc;
        logic [31:0] exp_ins;
        logic        exp_bd;
        logic [4:0]  exp_ex;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic ack, input logic [31:0] rdata, input logic lk, input logic jump,
        input logic br, input logic [31:0] target, input logic exc, input logic eret,
        input logic [31:0] epc, input logic exp_req, input logic [31:0] exp_addr,
        input logic exp_fstall, input logic [31:0] exp_pc, input logic [31:0] exp_ins,
        input logic exp_bd, input logic [4:0] exp_ex);
        vec_t v;
        v.ack = ack;   v.rdata = rdata;   v.lock = lk;     v.jump = jump;
        v.br = br;     v.target = target; v.exc = exc;     v.eret = eret;
        v.epc = epc;   v.exp_req = exp_req; v.exp_addr = exp_addr;
        v.exp_fstall = exp_fstall; v.exp_pc = exp_pc; v.exp_ins = exp_ins;
        v.exp_bd = exp_bd; v.exp_ex = exp_ex;
        return v;
    endfunction

    // Called at a falling edge: drive, check handshake outputs, clock once, check bundle.
    task automatic cycle(input vec_t v, input string tag);
        im.im_ack   = v.ack;
        im.im_rdata = v.rdata;
        lock        = v.lock;
        I_jump      = v.jump;
        I_br_taken  = v.br;
        I_br_target = v.target;
        I_exc_req   = v.exc;
        I_eret      = v.eret;
        I_epc       = v.epc;
        #1;
        check({tag, " im_req"},   32'(im.im_req), 32'(v.exp_req));
        check({tag, " im_addr"},  im.im_addr,     v.exp_addr);
        check({tag, " O_fstall"}, 32'(O_fstall),  32'(v.exp_fstall));
        @(posedge clk);
        #1;
        check({tag, " O_pc"},  O_pc,        v.exp_pc);
        check({tag, " O_ins"}, O_ins,       v.exp_ins);
        check({tag, " O_bd"},  32'(O_bd),   32'(v.exp_bd));
        check({tag, " O_ex"},  32'(O_ex),   32'(v.exp_ex));
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " O_pc"},     O_pc,           32'h0000_3000);
        check({tag, " O_ins"},    O_ins,          32'h0);
        check({tag, " O_ex"},     32'(O_ex),      32'h0);
        check({tag, " O_bd"},     32'(O_bd),      32'h0);
        check({tag, " im_req"},   32'(im.im_req), 32'h0);
        check({tag, " O_fstall"}, 32'(O_fstall),  32'h1);
        check({tag, " im_addr"},  im.im_addr,     32'h0000_3000);
    endtask

    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    vec_t tbl [20];

    initial begin
        // ack rdata lock jump br target exc eret epc | req addr fstall | pc ins bd ex
        tbl[0]  = mk(1, 32'h0,         0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 32'h3000, 1, 32'h3000, 32'h0,         0, 5'd0);
        tbl[1]  = mk(1, 32'hA000_0000, 0, 0, 0, 32'h0,    0, 0, 32'h0,    1, 32'h3000, 0, 32'h3000, 32'hA000_0000, 0, 5'd0);
        tbl[2]  = mk(1, 32'hA000_0001, 0, 1, 0, 32'h0,    0, 0, 32'h0,    1, 32'h3004, 0, 32'h3004, 32'hA000_0001, 1, 5'd0);
        tbl[3]  = mk(1, 32'hA000_0002, 0, 0, 0, 32'h0,    0, 0, 32'h0,    1, 32'h3008, 0, 32'h3008, 32'hA000_0002, 0, 5'd0);
        tbl[4]  = mk(0, 32'h0,         0, 0, 0, 32'h0,    0, 0, 32'h0,    1, 32'h300C, 1, 32'h3008, 32'hA000_0002, 0, 5'd0);
        tbl[5]  = mk(0, 32'h0,         0, 0, 1, 32'h3400, 0, 0, 32'h0,    1, 32'h300C, 1, 32'h3008, 32'hA000_0002, 0, 5'd0);
        tbl[6]  = mk(1, DEAD,          0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 32'h3400, 1, 32'h3008, 32'hA000_0002, 0, 5'd0);
        tbl[7]  = mk(1, 32'hB000_0000, 0, 0, 0, 32'h0,    0, 0, 32'h0,    1, 32'h3400, 0, 32'h3400, 32'hB000_0000, 0, 5'd0);
        tbl[8]  = mk(1, 32'hB000_0001, 1, 1, 0, 32'h0,    0, 0, 32'h0,    1, 32'h3404, 0, 32'h3404, 32'hB000_0001, 1, 5'd0);
        tbl[9]  = mk(0, 32'h0,         1, 0, 0, 32'h0,    0, 0, 32'h0,    0, 32'h3408, 0, 32'h3404, 32'hB000_0001, 1, 5'd0);
        tbl[10] = mk(0, 32'h0,         0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 32'h3408, 0, 32'h3404, 32'hB000_0001, 1, 5'd0);
        tbl[11] = mk(1, 32'hC000_0000, 1, 1, 1, 32'h3800, 1, 0, 32'h0,    1, 32'h3408, 0, 32'h3404, 32'h0,         0, 5'd0);
        tbl[12] = mk(1, 32'hC000_0001, 0, 0, 0, 32'h0,    0, 0, 32'h0,    1, 32'h4180, 0, 32'h4180, 32'hC000_0001, 0, 5'd0);
        tbl[13] = mk(0, 32'h0,         0, 0, 0, 32'h0,    1, 0, 32'h0,    1, 32'h4184, 1, 32'h4180, 32'h0,         0, 5'd0);
        tbl[14] = mk(1, DEAD,          0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 32'h4180, 1, 32'h4180, 32'h0,         0, 5'd0);
        tbl[15] = mk(1, 32'hC000_0002, 0, 0, 0, 32'h0,    0, 0, 32'h0,    1, 32'h4180, 0, 32'h4180, 32'hC000_0002, 0, 5'd0);
        tbl[16] = mk(0, 32'h0,         0, 0, 0, 32'h0,    0, 1, 32'h3100, 1, 32'h4184, 1, 32'h4180, 32'hC000_0002, 0, 5'd0);
        tbl[17] = mk(0, 32'h0,         0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 32'h3100, 1, 32'h4180, 32'hC000_0002, 0, 5'd0);
        tbl[18] = mk(1, DEAD,          0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 32'h3100, 1, 32'h4180, 32'hC000_0002, 0, 5'd0);
        tbl[19] = mk(1, 32'hD000_0000, 0, 1, 0, 32'h0,    0, 0, 32'h0,    1, 32'h3100, 0, 32'h3100, 32'hD000_0000, 1, 5'd0);

        reset = 1'b0;
        lock = 1'b0; I_br_taken = 1'b0; I_br_target = '0; I_jump = 1'b0;
        I_exc_req = 1'b0; I_eret = 1'b0; I_epc = '0;
        im.im_ack = 1'b0; im.im_rdata = '0;

        @(negedge clk);
        check_reset_values("rst");
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i], $sformatf("v%0d", i));
        end

        // Leave a request pending at 0x3104, then reset in the middle of it.
        cycle(mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h3104, 1, 32'h3100, 32'hD000_0000, 1, 5'd0), "pend");
        im.im_ack = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_values("midrst");
        im.im_ack   = 1'b1;
        im.im_rdata = DEAD;
        @(negedge clk);
        reset = 1'b1;
        // Late ack during IDLE must be ignored.
        cycle(mk(1, DEAD, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h3000, 1, 32'h3000, 32'h0, 0, 5'd0), "idle_ack");
        cycle(mk(1, 32'hE000_0000, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h3000, 0, 32'h3000, 32'hE000_0000, 0, 5'd0), "first");

        // Three wait states at 0x3004.
        for (int i = 0; i < 3; i++) begin
            cycle(mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h3004, 1, 32'h3000, 32'hE000_0000, 0, 5'd0),
                  $sformatf("wait%0d", i));
        end
        cycle(mk(1, 32'hE000_0001, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h3004, 0, 32'h3004, 32'hE000_0001, 0, 5'd0), "waitdone");

        // ERET to a misaligned EPC while a request is pending.
        cycle(mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 32'h3002, 1, 32'h3008, 1, 32'h3004, 32'hE000_0001, 0, 5'd0), "eret");
        cycle(mk(1, DEAD,  0, 0, 0, 32'h0, 0, 0, 32'h0,    0, 32'h3002, 1, 32'h3004, 32'hE000_0001, 0, 5'd0), "eret_drop");
`ifdef FETCH_ADEL_CHECK_EN
        cycle(mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h3002, 0, 32'h3002, 32'h0, 0, 5'd4), "adel");
`else
        cycle(mk(1, 32'hF000_0000, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h3002, 0, 32'h3002, 32'hF000_0000, 0, 5'd0), "noadel");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
